// File: rtl/tlul2sram_pkg.sv
// Types and constants for the TL-UL to SRAM response adapter.
package tlul2sram_pkg;

   import top_pkg::*;

   // TL-UL A-channel opcodes
   localparam logic [2:0] OpPutFull    = 3'h0;
   localparam logic [2:0] OpPutPartial = 3'h1;
   localparam logic [2:0] OpGet        = 3'h4;

   // TL-UL D-channel opcodes
   localparam logic [2:0] OpAccessAck     = 3'h0;
   localparam logic [2:0] OpAccessAckData = 3'h1;

   // SRAM read data arrives this many cycles after the read strobe
   localparam int RdLatency = 1;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic [TL_DUW-1:0] d_user;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;

   // One queued D-channel response; opcode is already the response opcode
   typedef struct packed {
      logic [2:0]        opcode;
      logic [TL_AIW-1:0] source;
      logic [TL_SZW-1:0] size;
      logic              error;
      logic [TL_DW-1:0]  data;
   } rsp_entry_t;

   // Request captured in the cycle after acceptance, waiting for rdata
   typedef struct packed {
      logic              valid;
      logic [2:0]        opcode;
      logic [TL_AIW-1:0] source;
      logic [TL_SZW-1:0] size;
      logic              error;
      logic              is_read;
   } pend_t;

   typedef enum logic [2:0] {
      ErrNone,
      ErrOpcode,
      ErrSize,
      ErrAlign,
      ErrRange,
      ErrMask
   } err_cause_e;

endpackage

// File: rtl/top_pkg.sv
// Global TL-UL bus widths shared by every TL-UL agent in the system.
package top_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_SZW = 2;
   localparam int TL_DUW = 4;

endpackage

// File: rtl/tlul2sram_rsp_fifo.sv
// Small response FIFO: register-array storage, async active-high reset on
// the control state, arbitrary depth with pointers wrapping at Depth.
module tlul2sram_rsp_fifo #(
   parameter  int Width = 8,
   parameter  int Depth = 4,
   localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             rd_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wptr_reg, rptr_reg;
   logic [CntW-1:0]  cnt_reg;
   logic             wr_en, rd_en;

   assign empty_o = (cnt_reg == '0);
   assign full_o  = (cnt_reg == CntW'(Depth));
   assign count_o = cnt_reg;
   assign rdata_o = mem[rptr_reg];

   // a write into a full FIFO is fine when the head leaves in the same cycle
   assign wr_en = wr_i && (!full_o || rd_i);
   assign rd_en = rd_i && !empty_o;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // storage array, written only; no reset needed on the data
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wptr_reg] <= wdata_i;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_reg <= '0;
         rptr_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         if (wr_en) wptr_reg <= ptr_inc(wptr_reg);
         if (rd_en) rptr_reg <= ptr_inc(rptr_reg);
         case ({wr_en, rd_en})
            2'b10:   cnt_reg <= cnt_reg + CntW'(1);
            2'b01:   cnt_reg <= cnt_reg - CntW'(1);
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

endmodule

// File: rtl/tlul2sram_rsp.sv
// TL-UL device adapter driving a 1-cycle-latency single-port SRAM.
// Define TLUL2SRAM_ERR_CHK_EN to enable request legality checks; without it
// every request reaches the SRAM and d_error is always 0.
module tlul2sram_rsp
   import top_pkg::*;
   import tlul2sram_pkg::*;
#(
   parameter int SramAw   = 12,
   parameter int SramDw   = 32,
   parameter int RspDepth = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  tl_h2d_t           tl_i,
   output tl_d2h_t           tl_o,
   output logic              req_o,
   output logic              we_o,
   output logic [SramAw-1:0] addr_o,
   output logic [SramDw-1:0] wdata_o,
   output logic [SramDw-1:0] wmask_o,
   input  logic [SramDw-1:0] rdata_i
);

   localparam int CntW = $clog2(RspDepth + 1);

   if (SramDw != TL_DW) begin : gen_dw_chk
      $error("SramDw must equal TL_DW");
   end
   if (RspDepth < 2 || RspDepth > 8) begin : gen_depth_chk
      $error("RspDepth must be within 2..8");
   end
   if (RdLatency != 1) begin : gen_lat_chk
      $error("pending stage assumes a 1-cycle SRAM read latency");
   end

   logic            ready_reg, ready_next;
   pend_t           pend_reg, pend_next;
   err_cause_e      err_cause;
   logic            req_err, accept, push, pop;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_cnt;
   logic [CntW:0]   occ_next;
   rsp_entry_t      push_entry, head_entry;
   logic            unused_bits;

`ifdef TLUL2SRAM_ERR_CHK_EN
   // classify the A-channel request; first failing rule wins
   always_comb begin
      err_cause = ErrNone;
      if (tl_i.a_opcode != OpGet && tl_i.a_opcode != OpPutFull &&
          tl_i.a_opcode != OpPutPartial) begin
         err_cause = ErrOpcode;
      end else if (tl_i.a_size > TL_SZW'(2)) begin
         err_cause = ErrSize;
      end else if (tl_i.a_address[1:0] != 2'b00) begin
         err_cause = ErrAlign;
      end else if (|(tl_i.a_address >> (SramAw + 2))) begin
         err_cause = ErrRange;
      end else if (tl_i.a_opcode == OpPutFull && tl_i.a_mask != '1) begin
         err_cause = ErrMask;
      end
   end
`else
   assign err_cause = ErrNone;
`endif

   assign req_err = (err_cause != ErrNone);
   assign accept  = tl_i.a_valid && ready_reg;

   // SRAM is driven straight from the A channel in the accept cycle
   assign req_o   = accept && !req_err;
   assign we_o    = req_o && (tl_i.a_opcode != OpGet);
   assign addr_o  = tl_i.a_address[SramAw+1:2];
   assign wdata_o = tl_i.a_data;

   for (genvar gi = 0; gi < SramDw / 8; gi++) begin : gen_wmask
      assign wmask_o[8*gi +: 8] = {8{tl_i.a_mask[gi]}};
   end

   // capture the accepted request so it can meet its read data next cycle
   always_comb begin
      pend_next = '0;
      if (accept) begin
         pend_next.valid   = 1'b1;
         pend_next.opcode  = tl_i.a_opcode;
         pend_next.source  = tl_i.a_source;
         pend_next.size    = tl_i.a_size;
         pend_next.error   = req_err;
         pend_next.is_read = !req_err && (tl_i.a_opcode == OpGet);
      end
   end

   // pending stage register; reset drops any request whose rdata is in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pend_reg <= '0;
      else       pend_reg <= pend_next;
   end

   // build the response entry from the pending request and SRAM data
   always_comb begin
      push_entry        = '0;
      push_entry.opcode = (pend_reg.opcode == OpGet) ? OpAccessAckData : OpAccessAck;
      push_entry.source = pend_reg.source;
      push_entry.size   = pend_reg.size;
      push_entry.error  = pend_reg.error;
      if (pend_reg.is_read) begin
         push_entry.data = rdata_i;
      end else if (pend_reg.error && pend_reg.opcode == OpGet) begin
         push_entry.data = '1;
      end
   end

   assign push = pend_reg.valid;
   assign pop  = !fifo_empty && tl_i.d_ready;

   tlul2sram_rsp_fifo #(
      .Width ($bits(rsp_entry_t)),
      .Depth (RspDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_i    (push),
      .wdata_i (push_entry),
      .rd_i    (pop),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // next-cycle occupancy (queued + pending) decides next-cycle a_ready,
   // so a_ready is a flop and has no combinational path from d_ready
   always_comb begin
      occ_next   = {1'b0, fifo_cnt} + {{CntW{1'b0}}, push}
                 + {{CntW{1'b0}}, accept} - {{CntW{1'b0}}, pop};
      ready_next = (occ_next < (CntW + 1)'(RspDepth));
   end

   // a_ready register, held low throughout reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ready_reg <= 1'b0;
      else       ready_reg <= ready_next;
   end

   // D channel presents the FIFO head; all fields read 0 when idle
   always_comb begin
      tl_o         = '0;
      tl_o.a_ready = ready_reg;
      tl_o.d_valid = !fifo_empty;
      if (!fifo_empty) begin
         tl_o.d_opcode = head_entry.opcode;
         tl_o.d_source = head_entry.source;
         tl_o.d_size   = head_entry.size;
         tl_o.d_error  = head_entry.error;
         tl_o.d_data   = head_entry.data;
      end
   end

   assign unused_bits = ^{tl_i.a_param, tl_i.a_address[1:0],
                          tl_i.a_address[TL_AW-1:SramAw+2], fifo_full};

endmodule
